// File: rtl/add_sub_pkg.sv
// Shared constants and the skewed-pipeline stage register layout for add_sub_pipe.
package add_sub_pkg;

   localparam int ADD_SUB_WIDTH  = 24;
   localparam int ADD_SUB_STAGES = 3;
   // Operand fields are sized for the widest supported WIDTH; only [WIDTH-1:0] is live.
   localparam int ADD_SUB_MAX_W  = 64;

   typedef struct packed {
      logic                     valid;
      logic                     sub;
      logic                     carry;  // carry out of the slice resolved in this stage
      logic                     ovf;
      logic                     zero;
      logic [ADD_SUB_MAX_W-1:0] a;
      logic [ADD_SUB_MAX_W-1:0] b;      // addend already conditionally inverted
      logic [ADD_SUB_MAX_W-1:0] sum;    // lower slices resolved so far
   } stage_t;

endpackage

// File: rtl/add_sub_seg.sv
// SEG-bit ripple-carry add segment; exposes the carry into its MSB so the
// top stage can derive signed overflow as cout ^ msb_cin.
module add_sub_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           msb_cin
);

   logic [SEG:0] c;

   always_comb begin
      c   = '0;
      sum = '0;
      c[0] = cin;
      for (int i = 0; i < SEG; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout    = c[SEG];
   assign msb_cin = c[SEG-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Skewed-pipeline adder/subtractor: stage k resolves bits [k*SEG +: SEG].
// Optional macro ADD_SUB_PIPE_SAT_EN saturates o_data to signed max/min on overflow.
module add_sub_pipe
   import add_sub_pkg::*;
#(
   parameter int WIDTH  = ADD_SUB_WIDTH,
   parameter int STAGES = ADD_SUB_STAGES
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data_one,
   input  logic [WIDTH-1:0] i_data_two,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_carry,
   output logic             o_overflow,
   output logic             o_zero
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if (((WIDTH % STAGES) != 0) || (WIDTH > ADD_SUB_MAX_W)) begin : g_bad_cfg
      $error("add_sub_pipe: WIDTH must be a multiple of STAGES and fit ADD_SUB_MAX_W");
   end

   // Handshake: a beat moves on either side only when advance is high; the
   // whole pipeline (including the output rank) stalls together otherwise.
   logic                        advance;
   stage_t [STAGES-1:0]         cur;
   stage_t [STAGES-1:0]         nxt;
   stage_t [STAGES-1:0]         pipe_q;
   logic   [STAGES-1:0][SEG-1:0] seg_sum;
   logic   [STAGES-1:0]         seg_cout;
   logic   [STAGES-1:0]         seg_msb_cin;
   logic   [WIDTH-1:0]          res_last;
   logic                        ovf_last;
   logic                        unused_tail;

   assign advance = !o_valid || i_ready;
   assign o_ready = advance;

   always_comb begin
      cur = '0;
      cur[0].valid            = i_valid;
      cur[0].sub              = i_sub;
      cur[0].carry            = i_sub;
      cur[0].a[WIDTH-1:0]     = i_data_one;
      cur[0].b[WIDTH-1:0]     = i_data_two ^ {WIDTH{i_sub}};
      for (int k = 1; k < STAGES; k++) begin
         cur[k] = pipe_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      add_sub_seg #(
         .SEG (SEG)
      ) u_seg (
         .a       (cur[k].a[k*SEG +: SEG]),
         .b       (cur[k].b[k*SEG +: SEG]),
         .cin     (cur[k].carry),
         .sum     (seg_sum[k]),
         .cout    (seg_cout[k]),
         .msb_cin (seg_msb_cin[k])
      );
   end

   always_comb begin
      nxt = cur;
      for (int k = 0; k < STAGES; k++) begin
         nxt[k].sum[k*SEG +: SEG] = seg_sum[k];
         nxt[k].carry             = seg_cout[k];
      end
      ovf_last = seg_cout[LAST] ^ seg_msb_cin[LAST];
`ifdef ADD_SUB_PIPE_SAT_EN
      if (ovf_last) begin
         res_last = cur[LAST].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res_last = nxt[LAST].sum[WIDTH-1:0];
      end
`else
      res_last = nxt[LAST].sum[WIDTH-1:0];
`endif
      nxt[LAST].sum[WIDTH-1:0] = res_last;
      nxt[LAST].ovf            = ovf_last;
      nxt[LAST].zero           = (res_last == '0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pipe_q <= '0;
      end else if (advance) begin
         pipe_q <= nxt;
      end
   end

   // The final rank doubles as the registered output beat.
   assign o_valid    = pipe_q[LAST].valid;
   assign o_data     = pipe_q[LAST].sum[WIDTH-1:0];
   assign o_carry    = pipe_q[LAST].carry;
   assign o_overflow = pipe_q[LAST].ovf;
   assign o_zero     = pipe_q[LAST].zero;

   assign unused_tail = ^{pipe_q[LAST], seg_msb_cin};

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=24, STAGES=3): directed corner beats,
// random beats with bubbles, a mid-stream stall, random backpressure and a mid-flight reset.
module tb_add_sub_pipe;

   localparam int WIDTH  = 24;
   localparam int STAGES = 3;
   localparam int RW     = WIDTH + 3;
`ifdef ADD_SUB_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data_one;
   logic [WIDTH-1:0] i_data_two;
   logic             i_sub;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;
   logic             o_carry;
   logic             o_overflow;
   logic             o_zero;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int in_count  = 0;
   int out_count = 0;
   bit mon_en    = 1'b0;
   bit no_bp     = 1'b1;
   bit bp_done   = 1'b0;

   // expected {data, carry, overflow, zero} per accepted beat, in order
   logic [RW-1:0] exp_q[$];
   int            acc_q[$];
   logic [RW-1:0] mon_exp;
   int            mon_lat;

   // ---------------- clock / reset block ----------------
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   add_sub_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data_one (i_data_one),
      .i_data_two (i_data_two),
      .i_sub      (i_sub),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_carry    (o_carry),
      .o_overflow (o_overflow),
      .o_zero     (o_zero)
   );

   // ---------------- reference model ----------------
   function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic sub);
      longint           sa, sb, st, smax, smin;
      longint unsigned  ua, ub;
      logic [WIDTH-1:0] res;
      logic             carry, ovf;
      smax = (longint'(1) << (WIDTH-1)) - 1;
      smin = -(longint'(1) << (WIDTH-1));
      ua = longint'(a);
      ub = longint'(b);
      sa = a[WIDTH-1] ? longint'(a) - (longint'(1) << WIDTH) : longint'(a);
      sb = b[WIDTH-1] ? longint'(b) - (longint'(1) << WIDTH) : longint'(b);
      if (sub) begin
         st    = sa - sb;
         res   = WIDTH'(ua - ub);
         carry = (ua >= ub);
      end else begin
         st    = sa + sb;
         res   = WIDTH'(ua + ub);
         carry = ((ua + ub) >= (longint'(1) << WIDTH));
      end
      ovf = (st > smax) || (st < smin);
      if (SAT && ovf) res = (st > smax) ? WIDTH'(smax) : WIDTH'(smin);
      return {res, carry, ovf, (res == '0)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                       input logic [RW-1:0] exp);
      bit rdy;
      int n;
      rdy = 1'b0;
      n   = 0;
      i_valid    = 1'b1;
      i_data_one = a;
      i_data_two = b;
      i_sub      = sub;
      while (!rdy && n < 200) begin
         @(negedge i_clk);
         rdy = o_ready;
         if (rdy) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
            in_count++;
         end
         @(posedge i_clk);
         #1;
         n++;
      end
      checks++;
      if (!rdy) begin
         failures++;
         $display("FAIL send_accept got=ready_low expected=accepted within 200 cycles");
      end
      i_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [WIDTH-1:0] a, b;
      logic             s;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      s = 1'($urandom_range(0, 1));
      send(a, b, s, model(a, b, s));
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      check1("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge i_clk) begin
      if (mon_en) begin
         check1("o_ready_rule", 32'(o_ready), 32'(!o_valid || i_ready));
         if (o_valid && i_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output got=%0h expected=no beat", o_data);
            end else begin
               mon_exp = exp_q.pop_front();
               mon_lat = cyc - acc_q.pop_front();
               checks++;
               if ({o_data, o_carry, o_overflow, o_zero} !== mon_exp) begin
                  failures++;
                  $display("FAIL result got=%h c=%b v=%b z=%b expected=%h c=%b v=%b z=%b",
                           o_data, o_carry, o_overflow, o_zero, mon_exp[RW-1:3], mon_exp[2],
                           mon_exp[1], mon_exp[0]);
               end
               if (no_bp) check1("latency", 32'(mon_lat), 32'(STAGES));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      i_rst_n    = 1'b0;
      i_valid    = 1'b0;
      i_ready    = 1'b1;
      i_sub      = 1'b0;
      i_data_one = '0;
      i_data_two = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check1("rst_o_valid", 32'(o_valid), 32'd0);
      check1("rst_o_data", 32'(o_data), 32'd0);
      check1("rst_o_carry", 32'(o_carry), 32'd0);
      check1("rst_o_overflow", 32'(o_overflow), 32'd0);
      check1("rst_o_zero", 32'(o_zero), 32'd0);
      i_rst_n = 1'b1;
      mon_en  = 1'b1;

      // directed corners, back to back
      send(24'h000001, 24'hFFFFFF, 1'b0, {24'h000000, 1'b1, 1'b0, 1'b1});
      send(24'h7FFFFF, 24'hFFFFFF, 1'b1, {(SAT ? 24'h7FFFFF : 24'h800000), 1'b0, 1'b1, 1'b0});
      send(24'h000005, 24'h000005, 1'b1, {24'h000000, 1'b1, 1'b0, 1'b1});
      send(24'h00FFFF, 24'h000001, 1'b0, {24'h010000, 1'b0, 1'b0, 1'b0});
      send(24'h7FFFFF, 24'h000001, 1'b0, {(SAT ? 24'h7FFFFF : 24'h800000), 1'b0, 1'b1, 1'b0});
      send(24'h800000, 24'h800000, 1'b0, {(SAT ? 24'h800000 : 24'h000000), 1'b1, 1'b1, !SAT});
      send(24'h000000, 24'h000001, 1'b1, {24'hFFFFFF, 1'b0, 1'b0, 1'b0});
      wait_empty();

      // random beats with bubbles
      for (int i = 0; i < 40; i++) begin
         send_rand();
         repeat ($urandom_range(0, 2)) begin
            @(posedge i_clk);
            #1;
         end
      end
      wait_empty();

      // 100 back-to-back beats with a 4-cycle downstream stall
      no_bp = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) send_rand();
         end
         begin
            repeat (50) @(posedge i_clk);
            #1;
            i_ready = 1'b0;
            repeat (4) @(posedge i_clk);
            #1;
            i_ready = 1'b1;
         end
      join
      wait_empty();

      // random backpressure
      bp_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) send_rand();
            bp_done = 1'b1;
         end
         begin
            while (!bp_done) begin
               @(posedge i_clk);
               #1;
               i_ready = ($urandom_range(0, 3) != 0);
            end
            i_ready = 1'b1;
         end
      join
      wait_empty();
      check1("beats_in_eq_out", 32'(out_count), 32'(in_count));

      // reset with three beats in flight
      i_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_rand();
      check1("inflight_o_valid", 32'(o_valid), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check1("midrst_o_valid", 32'(o_valid), 32'd0);
      check1("midrst_o_data", 32'(o_data), 32'd0);
      check1("midrst_flags", 32'({o_carry, o_overflow, o_zero}), 32'd0);
      exp_q.delete();
      acc_q.delete();
      in_count -= 3;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check1("post_rst_o_ready", 32'(o_ready), 32'd1);
      check1("post_rst_o_valid", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      no_bp   = 1'b1;
      send(24'h123456, 24'h000ABC, 1'b1, model(24'h123456, 24'h000ABC, 1'b1));
      send_rand();
      wait_empty();
      check1("final_in_eq_out", 32'(out_count), 32'(in_count));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
